// File: rtl/disp_pkg.sv
// Shared symbol-code definitions for the digit scanner and the 5-bit seven-segment decoder.
package disp_pkg;

    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'd31;

    localparam logic [CODE_W-1:0] SYM_0 = 5'd0;
    localparam logic [CODE_W-1:0] SYM_1 = 5'd1;
    localparam logic [CODE_W-1:0] SYM_2 = 5'd2;
    localparam logic [CODE_W-1:0] SYM_3 = 5'd3;
    localparam logic [CODE_W-1:0] SYM_4 = 5'd4;
    localparam logic [CODE_W-1:0] SYM_5 = 5'd5;
    localparam logic [CODE_W-1:0] SYM_6 = 5'd6;
    localparam logic [CODE_W-1:0] SYM_7 = 5'd7;
    localparam logic [CODE_W-1:0] SYM_8 = 5'd8;
    localparam logic [CODE_W-1:0] SYM_9 = 5'd9;
    localparam logic [CODE_W-1:0] SYM_H = 5'd10;
    localparam logic [CODE_W-1:0] SYM_L = 5'd11;
    localparam logic [CODE_W-1:0] SYM_P = 5'd12;
    localparam logic [CODE_W-1:0] SYM_U = 5'd13;
    localparam logic [CODE_W-1:0] SYM_A = 5'd14;
    localparam logic [CODE_W-1:0] SYM_B = 5'd15;
    localparam logic [CODE_W-1:0] SYM_C = 5'd16;
    localparam logic [CODE_W-1:0] SYM_D = 5'd17;
    localparam logic [CODE_W-1:0] SYM_E = 5'd18;
    localparam logic [CODE_W-1:0] SYM_F = 5'd19;
    localparam logic [CODE_W-1:0] SYM_R = 5'd20;
    localparam logic [CODE_W-1:0] SYM_X = 5'd21;

    // Codes above SYM_X are rendered as a dash by the decoder.
    function automatic logic code_is_symbol(input logic [CODE_W-1:0] code);
        return code <= SYM_X;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and raises a one-cycle tick at terminal count.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed N-digit display scanner with double-buffered codes.
// Optional per-digit blinking is built when DISP_BLINK_EN is defined.
module display_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [CODE_W*N_DIGITS-1:0] codes_in,
`ifdef DISP_BLINK_EN
    input  logic [N_DIGITS-1:0]        blink_mask,
`endif
    output logic [CODE_W-1:0]          code_out,
    output logic [N_DIGITS-1:0]        anode,
    output logic                       frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    typedef logic [N_DIGITS-1:0][CODE_W-1:0] codes_t;

    logic             tick, wrap;
    logic [IDX_W-1:0] idx_q, idx_d;
    codes_t           pend_q, pend_d, act_q, act_d;
    logic [CODE_W-1:0]   code_q;
    logic [N_DIGITS-1:0] anode_q, anode_d, blank_d;
    logic                frame_q;

    tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign wrap = tick && (idx_q == IDX_W'(N_DIGITS - 1));

    // pend_d already carries a same-cycle load, so a load on the wrapping
    // tick reaches the active buffer without a frame of delay.
    always_comb begin
        idx_d  = idx_q;
        pend_d = pend_q;
        act_d  = act_q;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
        if (load) pend_d = codes_in;
        if (wrap) act_d = pend_d;
    end

`ifdef DISP_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [FRM_W-1:0]    frm_q, frm_d;
    logic                phase_q, phase_d;
    logic [N_DIGITS-1:0] mpend_q, mpend_d, mact_q, mact_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        mpend_d = load ? blink_mask : mpend_q;
        mact_d  = wrap ? mpend_d : mact_q;
        if (wrap) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
        blank_d = phase_d ? '0 : mact_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q   <= '0;
            phase_q <= 1'b1;
            mpend_q <= '0;
            mact_q  <= '0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
            mpend_q <= mpend_d;
            mact_q  <= mact_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = (BLINK_FRAMES != 0);
    assign blank_d      = '0;
`endif

    assign anode_d = ~(N_DIGITS'(1) << idx_d) | blank_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            code_q  <= '0;
            anode_q <= '1;
            frame_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            code_q  <= act_d[idx_d];
            anode_q <= anode_d;
            frame_q <= wrap;
        end
    end

    assign code_out   = code_q;
    assign anode      = anode_q;
    assign frame_done = frame_q;

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot (at least 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 250: frames per blink half-period (used only with DISP_BLINK_EN).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  input  1  one-cycle strobe that captures codes_in.
REQ-007 SHALL have port codes_in  input  5*N_DIGITS  symbol codes; digit k at bits [5k+4:5k]; codes 0-21 are defined symbols, others show a dash.
REQ-008 SHALL have port blink_mask  input  N_DIGITS  per-digit blink enable, captured with load (present only with DISP_BLINK_EN).
REQ-009 SHALL have port code_out  output  5  code of the currently lit digit, fed to the 5-bit-to-seven-segment decoder.
REQ-010 SHALL have port anode  output  N_DIGITS  digit enables, active-low, at most one bit low.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-012 SHALL count clk cycles 0..REFRESH_DIV-1 in a prescaler and assert an internal tick at terminal count, then wrap to 0.
REQ-013 SHALL advance digit index on tick, N_DIGITS-1 -> 0 wrap; frame_done SHALL be registered, high in the cycle after the wrapping tick.
REQ-014 SHALL drive anode = ~(1 << idx) and code_out = active[idx], both registered and mutually aligned (same cycle change).
REQ-015 SHALL double-buffer: load writes a pending register; pending copies to active only on the wrapping tick (no tearing mid-frame).
REQ-016 SHALL, on load coinciding with the wrapping tick, copy codes_in directly into active, and also into pending.
REQ-017 SHALL keep the last captured value when load repeats within a frame.
REQ-018 SHALL pass every code value unmodified to code_out; invalid codes are not filtered.
REQ-019 SHALL hold code_out and anode stable for exactly REFRESH_DIV cycles per digit in steady state.

Reset
REQ-020 SHALL, while rst_n low: prescaler 0, idx 0, pending and active all 0, code_out 0, anode all ones, frame_done 0, blink phase on.
REQ-021 SHALL drive anode = ~1 (digit 0 lit, code 0) from the first clk edge after rst_n release.
REQ-022 SHALL abort scan immediately on rst_n assertion mid-frame, with no completion of the current slot.

Configuration
REQ-023 SHALL, with DISP_BLINK_EN defined, count frames to BLINK_FRAMES and toggle a blink phase; in the off phase, digits whose mask bit is set SHALL have anode held high while code_out continues to follow the scan.
REQ-024 SHALL, without DISP_BLINK_EN, omit blink_mask, the frame counter and phase logic; anode behaves as if the mask is all zero.
REQ-025 SHALL apply blink_mask with the same pending/active double buffering as codes.

Structure
REQ-026 SHALL take CODE_W=5, CODE_BLANK=31 and symbol code constants (digits 0-9, H=10 ... X=21) from shared package disp_pkg, also used by the decoder.
REQ-027 SHALL implement the prescaler as sub-module tick_gen (parameter DIV; outputs one-cycle tick), reusable elsewhere in the design.

Verification (N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset release, no load -> anode cycles 1110,1101,1011,0111 every 4 clk, code_out 0; frame_done pulses every 16 clk.
REQ-029 load codes {3,2,1,0} at frame start -> next frame digit k shows code k; current frame unchanged.
REQ-030 load {10,11,12,13} mid-frame at digit 2 -> digits 2,3 keep old codes; new codes from next digit 0.
REQ-031 load on wrapping tick cycle with {21,20,19,18} -> digit 0 immediately shows 18, no one-frame delay.
REQ-032 rst_n low during digit 2 -> anode 1111, code_out 0 asynchronously; scan restarts at digit 0.
REQ-033 DISP_BLINK_EN, blink_mask 0010 -> digit 1 anode stays high for 2 frames out of every 4; other digits unaffected.
